// File: rtl/encode_scalar.sv
// encode_scalar: packs scalar_inst_t into the 32-bit scalar word stream, with an optional trailing literal word.
// Define ENCODE_SCALAR_CHECK_EN to drop illegal instructions and count them.
package common_pkg;
   localparam logic [7:0] LITERAL_CONSTANT = 8'hFF;
   typedef enum logic [2:0] {FMT_SOP2, FMT_SOP1, FMT_SOPK, FMT_SOPP, FMT_SOPC} scalar_fmt_t;
   typedef struct packed {
      logic [7:0]  op;
      logic [6:0]  dst;
      logic [7:0]  src0;
      logic [7:0]  src1;
      logic [15:0] imm16;
      logic [31:0] literal;
      scalar_fmt_t format;
   } scalar_inst_t;
endpackage

module encode_scalar
   import common_pkg::*;
#(
   parameter logic [7:0] LIT_CODE  = LITERAL_CONSTANT,
   parameter int          ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  scalar_inst_t         scalar_inst_in,
   output logic [31:0]          word_out,
   output logic                 word_valid,
   input  logic                 word_ready,
   output logic                 word_is_lit,
   output logic                 word_last,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count
);
   typedef enum logic [1:0] {S_EMPTY, S_BASE, S_LIT} state_t;
   state_t      state;
   scalar_fmt_t fmt;
   logic [31:0] lit_q, base;
   logic        accept, adv, to_lit, need_lit, illegal;
   assign fmt      = scalar_inst_in.format;
   assign adv      = word_valid & word_ready;
   assign to_lit   = (state == S_BASE) & ~word_last;
   assign in_ready = ~reset & ((state == S_EMPTY) | (adv & word_last));
   assign accept   = in_valid & in_ready;
   assign need_lit = ((fmt inside {FMT_SOP1, FMT_SOP2, FMT_SOPC}) && scalar_inst_in.src0 == LIT_CODE) ||
                     ((fmt inside {FMT_SOP2, FMT_SOPC}) && scalar_inst_in.src1 == LIT_CODE);
   always_comb
      base = (fmt == FMT_SOP2) ? {2'b10, scalar_inst_in.op[6:0], scalar_inst_in.dst, scalar_inst_in.src1, scalar_inst_in.src0} :
             (fmt == FMT_SOP1) ? {2'b10, 7'b1111101, scalar_inst_in.dst, scalar_inst_in.op, scalar_inst_in.src0} :
             (fmt == FMT_SOPK) ? {2'b10, 2'b11, scalar_inst_in.op[4:0], scalar_inst_in.dst, scalar_inst_in.imm16} :
             (fmt == FMT_SOPC) ? {2'b10, 7'b1111110, scalar_inst_in.op[6:0], scalar_inst_in.src1, scalar_inst_in.src0} :
                                 {2'b10, 7'b1111111, scalar_inst_in.op[6:0], scalar_inst_in.imm16};
   // A new accept can only coincide with consuming a last word, so it never races the S_BASE->S_LIT step.
   always_ff @(posedge clk)
      if (reset) begin
         state       <= S_EMPTY;
         word_out    <= '0;
         word_valid  <= 1'b0;
         word_is_lit <= 1'b0;
         word_last   <= 1'b0;
         lit_q       <= '0;
      end else if (accept) begin
         state       <= illegal ? S_EMPTY : S_BASE;
         word_out    <= illegal ? '0 : base;
         word_valid  <= ~illegal;
         word_is_lit <= 1'b0;
         word_last   <= ~illegal & ~need_lit;
         lit_q       <= scalar_inst_in.literal;
      end else if (adv) begin
         state       <= to_lit ? S_LIT : S_EMPTY;
         word_out    <= to_lit ? lit_q : '0;
         word_valid  <= to_lit;
         word_is_lit <= to_lit;
         word_last   <= to_lit;
      end
`ifdef ENCODE_SCALAR_CHECK_EN
   assign illegal = (fmt == FMT_SOP2 && scalar_inst_in.op[6:5] == 2'b11) ||
                    (fmt == FMT_SOPK && scalar_inst_in.op[4:0] >= 5'b11101);
   always_ff @(posedge clk)
      if (reset) begin
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         err_pulse <= accept & illegal;
         if (accept & illegal & ~&err_count) err_count <= err_count + 1'b1;
      end
`else
   assign illegal   = 1'b0;
   assign err_pulse = 1'b0;
   assign err_count = '0;
`endif
endmodule

// File: tb/tb_encode_scalar.sv
// tb_encode_scalar: directed vectors plus randomized traffic against a queue-based reference model.
module tb_encode_scalar;
   import common_pkg::*;
   localparam logic [7:0] LIT = LITERAL_CONSTANT;
   logic         clk = 1'b0, reset, in_valid, in_ready, word_ready, word_valid, word_is_lit, word_last, err_pulse;
   logic [31:0]  word_out;
   logic [7:0]   err_count;
   scalar_inst_t inst;
   int           total = 0, passed = 0;
   logic [33:0]  q[$];
   always #5 clk = ~clk;

   encode_scalar dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .scalar_inst_in(inst),
      .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready), .word_is_lit(word_is_lit),
      .word_last(word_last), .err_pulse(err_pulse), .err_count(err_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic scalar_inst_t mk(input scalar_fmt_t f, input logic [7:0] op, input logic [6:0] dst,
                                       input logic [7:0] s0, input logic [7:0] s1, input logic [15:0] imm,
                                       input logic [31:0] lit);
      scalar_inst_t i;
      i.format = f; i.op = op; i.dst = dst; i.src0 = s0; i.src1 = s1; i.imm16 = imm; i.literal = lit;
      return i;
   endfunction

   function automatic logic [31:0] ref_base(input scalar_inst_t i);
      int unsigned op = i.op, dst = i.dst, s0 = i.src0, s1 = i.src1, imm = i.imm16, w = 32'h8000_0000;
      case (i.format)
         FMT_SOP2: w += (op % 128) * 32'h80_0000 + dst * 65536 + s1 * 256 + s0;
         FMT_SOP1: w += 125 * 32'h80_0000 + dst * 65536 + op * 256 + s0;
         FMT_SOPK: w += 3 * 32'h1000_0000 + (op % 32) * 32'h80_0000 + dst * 65536 + imm;
         FMT_SOPC: w += 126 * 32'h80_0000 + (op % 128) * 65536 + s1 * 256 + s0;
         default:  w += 127 * 32'h80_0000 + (op % 128) * 65536 + imm;
      endcase
      return w;
   endfunction

   function automatic bit ref_lit(input scalar_inst_t i);
      bit r0 = (i.format == FMT_SOP1 || i.format == FMT_SOP2 || i.format == FMT_SOPC) && i.src0 == LIT;
      bit r1 = (i.format == FMT_SOP2 || i.format == FMT_SOPC) && i.src1 == LIT;
      return r0 || r1;
   endfunction

   function automatic bit ref_illegal(input scalar_inst_t i);
`ifdef ENCODE_SCALAR_CHECK_EN
      return (i.format == FMT_SOP2 && (i.op % 128) >= 96) || (i.format == FMT_SOPK && (i.op % 32) >= 29);
`else
      return (i.format == FMT_SOP2) && 1'b0;
`endif
   endfunction

   initial begin
      int nw, nl, pend, exp_cnt;
      bit hold, exp_rdy, acc, exp_pulse;
      reset = 1'b1; in_valid = 1'b0; word_ready = 1'b0; inst = '0;
      step(); step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_valid", word_valid, 0);
      chk("rst_word", word_out, 0);
      chk("rst_last", word_last, 0);
      chk("rst_errcnt", err_count, 0);
      reset = 1'b0; #1;
      chk("post_rst_ready", in_ready, 1);
      // single-word SOP2
      inst = mk(FMT_SOP2, 8'h05, 7'h03, 8'h01, 8'h02, 16'h0, 32'h0); in_valid = 1'b1; word_ready = 1'b1;
      step(); in_valid = 1'b0; #1;
      chk("sop2_valid", word_valid, 1);
      chk("sop2_word", word_out, 32'h8283_0201);
      chk("sop2_last", word_last, 1);
      chk("sop2_islit", word_is_lit, 0);
      step();
      chk("sop2_drain", word_valid, 0);
      // SOP1 with literal, literal input changed after accept
      inst = mk(FMT_SOP1, 8'h04, 7'h07, LIT, 8'h00, 16'h0, 32'hDEAD_BEEF); in_valid = 1'b1;
      step(); in_valid = 1'b0; inst.literal = 32'h0; #1;
      chk("sop1_base", word_out, 32'hBE87_04FF);
      chk("sop1_base_last", word_last, 0);
      chk("sop1_base_ready", in_ready, 0);
      step();
      chk("sop1_lit", word_out, 32'hDEAD_BEEF);
      chk("sop1_lit_islit", word_is_lit, 1);
      chk("sop1_lit_last", word_last, 1);
      word_ready = 1'b0; #1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_word", word_out, 32'hDEAD_BEEF);
         chk("bp_valid", word_valid, 1);
         chk("bp_islit", word_is_lit, 1);
         chk("bp_in_ready", in_ready, 0);
         step();
      end
      inst = mk(FMT_SOP2, 8'h05, 7'h03, 8'h01, 8'h02, 16'h0, 32'h0); in_valid = 1'b1; word_ready = 1'b1; #1;
      chk("bp_release_ready", in_ready, 1);
      step(); in_valid = 1'b0; #1;
      chk("no_bubble_valid", word_valid, 1);
      chk("no_bubble_word", word_out, 32'h8283_0201);
      step();
      // SOPC with both sources literal
      inst = mk(FMT_SOPC, 8'h12, 7'h00, LIT, LIT, 16'h0, 32'h1234_5678); in_valid = 1'b1;
      step(); in_valid = 1'b0; #1;
      chk("sopc_base", word_out, 32'hBF12_FFFF);
      nw = 0; nl = 0;
      for (int k = 0; k < 5; k++) begin
         if (word_valid) begin nw++; nl += int'(word_is_lit); end
         step();
      end
      chk("sopc_words", nw, 2);
      chk("sopc_lits", nl, 1);
      // SOPK op 1F: illegal when checking is enabled
      inst = mk(FMT_SOPK, 8'h1F, 7'h05, 8'h0, 8'h0, 16'h1234, 32'h0); in_valid = 1'b1;
      step(); in_valid = 1'b0; #1;
`ifdef ENCODE_SCALAR_CHECK_EN
      chk("sopk_ill_valid", word_valid, 0);
      chk("sopk_ill_pulse", err_pulse, 1);
      chk("sopk_ill_cnt", err_count, 1);
      step();
      chk("sopk_ill_pulse_end", err_pulse, 0);
      chk("sopk_ill_cnt_hold", err_count, 1);
`else
      chk("sopk_word", word_out, 32'hBF85_1234);
      chk("sopk_pulse", err_pulse, 0);
      step();
`endif
      step();
      // reset while the literal word is pending
      inst = mk(FMT_SOP1, 8'h04, 7'h07, LIT, 8'h00, 16'h0, 32'hCAFE_F00D); in_valid = 1'b1;
      step(); in_valid = 1'b0; step();
      chk("rst_lit_pre", word_is_lit, 1);
      reset = 1'b1; step();
      chk("rst_lit_valid", word_valid, 0);
      chk("rst_lit_cnt", err_count, 0);
      chk("rst_lit_ready", in_ready, 0);
      reset = 1'b0; #1;
      chk("rst_lit_ready_after", in_ready, 1);
      for (int k = 0; k < 3; k++) begin
         chk("rst_no_stale", word_valid, 0);
         step();
      end
      // randomized traffic
      hold = 0; exp_cnt = 0; exp_pulse = 0;
      for (int c = 0; c < 1500; c++) begin
         if (!hold) begin
            in_valid = ($urandom_range(0, 3) != 0) && (c < 1480);
            inst = mk(scalar_fmt_t'($urandom_range(0, 4)), 8'($urandom), 7'($urandom),
                      ($urandom_range(0, 3) == 0) ? LIT : 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? LIT : 8'($urandom), 16'($urandom), $urandom);
         end
         word_ready = $urandom_range(0, 3) != 0;
         #1;
         chk("rnd_valid", word_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("rnd_word", word_out, q[0][31:0]);
            chk("rnd_islit", word_is_lit, q[0][33]);
            chk("rnd_last", word_last, q[0][32]);
         end
         pend = q.size();
         if (pend > 0 && word_ready) pend--;
         exp_rdy = pend == 0;
         chk("rnd_in_ready", in_ready, exp_rdy);
         chk("rnd_err_pulse", err_pulse, exp_pulse);
         chk("rnd_err_cnt", err_count, exp_cnt);
         if (q.size() != 0 && word_ready) void'(q.pop_front());
         acc = in_valid && exp_rdy;
         exp_pulse = acc && ref_illegal(inst);
         if (exp_pulse && exp_cnt < 255) exp_cnt++;
         if (acc && !ref_illegal(inst)) begin
            q.push_back({1'b0, !ref_lit(inst), ref_base(inst)});
            if (ref_lit(inst)) q.push_back({1'b1, 1'b1, inst.literal});
         end
         hold = in_valid && !acc;
         step();
      end
      chk("rnd_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
